imem_loader: RTL

Writer side of the instruction-memory interface. It receives a byte-serial program image over a valid/ready byte stream and assembles little-endian 32-bit words. It writes those words into instruction memory at sequential byte addresses and holds the core in reset until the image loads with a good checksum. It sits between the host byte link and the i_mem write port, and drives the core's reset input.

---
 rtl/imem_loader_pkg.sv | 35 +++
 rtl/imem_loader_word_assembler.sv | 50 +++++
 rtl/imem_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state encodings,
// error codes and word-assembly geometry.
package imem_loader_pkg;

    // FSM state encodings
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] LEN_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] CSUM   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    // err_code values
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    // Bytes per instruction word
    localparam int LANES = 4;

    // Width of the image-length field in the stream header
    localparam int LEN_W = 16;

    // States in which the loader takes bytes from the host link
    function automatic logic accepts_bytes(input logic [2:0] s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
    endfunction

    // States from which a start pulse launches a new load
    function automatic logic can_start(input logic [2:0] s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four stream bytes, least-significant first, into a 32-bit word.
// The fourth byte is not stored: it is combined straight into word_o so the
// word is available in the same cycle word_complete_o fires.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        shift_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_complete_o
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] shreg_q, shreg_d;

    // Next-state for the lane counter and the three-byte shift register
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        lane_d  = lane_q;
        shreg_d = shreg_q;
        if (shift_en_i) begin
            lane_d  = lane_q + 2'd1;
            shreg_d = {byte_i, shreg_q[23:8]};
        end
    end

    // Assembled word and completion pulse on the last byte lane
    always_comb begin
        word_o          = {byte_i, shreg_q};
        word_complete_o = shift_en_i && (lane_q == 2'(LANES - 1));
    end

    // Lane/shift state, cleared by reset or by the start of a new load
    always_ff @(posedge clk) begin
        // NOTE: state registers take non-blocking assignments so every
        // flop samples its inputs from before the edge.
        if (reset || clear_i) begin
            lane_q  <= '0;
            shreg_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed, XOR-checksummed
// byte image, writes it word by word into instruction memory and keeps the
// core in reset until a complete image with a good checksum has landed.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    // Index must be able to count up to DEPTH_WORDS itself
    localparam int              IDX_W     = $clog2(DEPTH_WORDS + 1);
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH_WORDS);

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [7:0]        csum_q, csum_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              core_reset_q, core_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              accept;
    logic              start_go;
    logic [LEN_W-1:0]  len_rx;
    logic [31:0]       asm_word;
    logic              asm_complete;

    // Handshake and start qualification
    always_comb begin
        byte_ready = accepts_bytes(state_q);
        accept     = byte_valid && byte_ready;
        start_go   = start && can_start(state_q);
        len_rx     = {byte_data, len_lo_q};
    end

    word_assembler u_word_assembler (
        .clk             (clk),
        .reset           (reset),
        .clear_i         (start_go),
        .shift_en_i      (accept && (state_q == DATA)),
        .byte_i          (byte_data),
        .word_o          (asm_word),
        .word_complete_o (asm_complete)
    );

    // Load FSM, running checksum, word index and write-port next state
    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        index_d      = index_q;
        csum_d       = csum_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        core_reset_d = core_reset_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        err_code_d   = err_code_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_go) begin
                    state_d      = LEN_LO;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    err_code_d   = ERR_NONE;
                    index_d      = '0;
                    csum_d       = '0;
                    busy_d       = 1'b1;
                    core_reset_d = 1'b1;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_lo_d = byte_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d = len_rx;
                    if (len_rx > DEPTH_LEN) begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_LEN;
                        busy_d     = 1'b0;
                    end else if (len_rx == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ byte_data;
                    if (asm_complete) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = asm_word;
                        wr_addr_d = ADDR_W'({index_q, 2'b00});
                        index_d   = index_q + IDX_W'(1);
                        if (LEN_W'(index_q) + LEN_W'(1) == len_q) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (byte_data == csum_q) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        core_reset_d = 1'b0;
                    end else begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset also cancels a pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            index_q      <= '0;
            csum_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            index_q      <= index_d;
            csum_q       <= csum_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;

endmodule
